instr_encoder: RTL and testbench

Streaming RV32I instruction encoder, the inverse of the core's opcode-to-control decoder. It accepts instruction fields (class, registers, funct codes, immediate) over a valid/ready handshake and packs them into 32-bit machine words. It writes each word sequentially into instruction memory through a write port with an auto-incrementing word address. It sits between the test/boot host and the instruction memory read by the datapath.

---
 rtl/instr_encoder.sv | 181 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs instruction fields into 32-bit words and
// streams them into instruction memory at auto-incrementing word addresses.
module instr_encoder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        cls,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

  localparam logic [2:0] CLS_LW  = 3'd0;
  localparam logic [2:0] CLS_SW  = 3'd1;
  localparam logic [2:0] CLS_R   = 3'd2;
  localparam logic [2:0] CLS_B   = 3'd3;
  localparam logic [2:0] CLS_I   = 3'd4;
  localparam logic [2:0] CLS_JAL = 3'd5;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W:0]    count_q, count_d;
  logic               err_q, err_d;
  logic               full_q, full_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [31:0]        wr_data_q, wr_data_d;

  logic signed [31:0] imm_s;
  logic               is_shift;
  logic               ok_i12;
  logic               ok_shamt;
  logic               ok_b;
  logic               ok_j;
  logic               legal;
  logic [31:0]        enc_word;
  logic               xfer;

  assign imm_s    = $signed(imm);
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign ok_i12   = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  assign ok_shamt = (imm_s >= 32'sd0) && (imm_s <= 32'sd31);
  assign ok_b     = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm[0];
  assign ok_j     = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm[0];

  assign in_ready = (state_q == RUN) && !start;
  assign xfer     = in_valid && in_ready;

  // Field packing and legality per instruction class
  always_comb begin
    enc_word = 32'h0;
    legal    = 1'b0;
    case (cls)
      CLS_LW: begin
        enc_word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
        legal    = ok_i12;
      end
      CLS_SW: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        legal    = ok_i12;
      end
      CLS_R: begin
        enc_word = {funct7, rs2, rs1, funct3, rd, OP_R};
        legal    = 1'b1;
      end
      CLS_B: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_B};
        legal    = ok_b;
      end
      CLS_I: begin
        if (is_shift) begin
          enc_word = {funct7, imm[4:0], rs1, funct3, rd, OP_I};
          legal    = ok_shamt;
        end else begin
          enc_word = {imm[11:0], rs1, funct3, rd, OP_I};
          legal    = ok_i12;
        end
      end
      CLS_JAL: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        legal    = ok_j;
      end
      default: begin
        enc_word = 32'h0;
        legal    = 1'b0;
      end
    endcase
  end

  // Next-state: start always wins over a same-cycle transfer
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    err_d     = err_q;
    full_d    = full_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (start) begin
      state_d = RUN;
      addr_d  = BASE;
      count_d = '0;
      err_d   = 1'b0;
      full_d  = 1'b0;
    end else if (xfer) begin
      if (legal) begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = enc_word;
        count_d   = count_q + CNT_ONE;
        if (addr_q == TOP_ADDR) begin
          state_d = FULL;
          full_d  = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= BASE;
      count_q   <= '0;
      err_q     <= 1'b0;
      full_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      full_q    <= full_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign count   = count_q;
  assign full    = full_q;
  assign err     = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: scoreboard of expected writes popped
// by a write monitor, plus per-scenario checks of count/err/full/in_ready.
module tb_instr_encoder;

  localparam int unsigned ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        cls;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .cls(cls), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .count(count), .full(full),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t               sb[$];
  wr_t               mon_e;
  int                checks   = 0;
  int                failures = 0;
  logic [ADDR_W-1:0] exp_addr;
  logic [ADDR_W:0]   exp_count;

  // Every observed write must match the oldest expected write
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%0d data=%h", wr_addr, wr_data);
      end else begin
        mon_e = sb.pop_front();
        if (wr_addr !== mon_e.addr || wr_data !== mon_e.data) begin
          failures++;
          $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                   wr_addr, wr_data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic send(input logic [2:0] c, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] im, input bit ok, input logic [31:0] word);
    cls = c; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL in_ready_run got=%b want=1", in_ready);
    end
    if (ok) begin
      sb.push_back({exp_addr, word});
      exp_addr  = exp_addr + 1'b1;
      exp_count = exp_count + 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (count !== exp_count) begin
      failures++;
      $display("FAIL count got=%0d want=%0d", count, exp_count);
    end
    if (!ok) begin
      checks++;
      if (err !== 1'b1) begin
        failures++;
        $display("FAIL err_sticky got=%b want=1", err);
      end
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL in_ready_start got=%b want=0", in_ready);
    end
    @(posedge clk); #1;
    start     = 1'b0;
    exp_addr  = '0;
    exp_count = '0;
    checks++;
    if (count !== 3'd0 || err !== 1'b0 || full !== 1'b0) begin
      failures++;
      $display("FAIL start_clear got count=%0d err=%b full=%b want 0 0 0", count, err, full);
    end
  endtask

  task automatic drain(input string name);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s missing_writes got=%0d want=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if (in_ready !== 1'b0 || wr_en !== 1'b0 || wr_addr !== 2'd0 || wr_data !== 32'h0 ||
        count !== 3'd0 || full !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL %s got rdy=%b we=%b a=%0d d=%h cnt=%0d full=%b err=%b want all 0",
               name, in_ready, wr_en, wr_addr, wr_data, count, full, err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    cls = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_ready got=%b want=0", in_ready);
    end
  endtask

  task automatic test_single();
    do_start();
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 1'b1, 32'h00500093);
    drain("single");
  endtask

  task automatic test_back_to_back();
    do_start();
    send(3'd0, 5'd2, 5'd1, 5'd0, 3'b010, 7'd0, 32'd8,  1'b1, 32'h0080A103);
    send(3'd1, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd12, 1'b1, 32'h0020A623);
    send(3'd2, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0,  1'b1, 32'h002081B3);
    drain("back_to_back");
  endtask

  task automatic test_branch_jal();
    do_start();
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd8,        1'b1, 32'h00208463);
    send(3'd5, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd16,       1'b1, 32'h010000EF);
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'b001, 7'd0, 32'hFFFFFFF8, 1'b1, 32'hFE209CE3);
    send(3'd0, 5'd1, 5'd2, 5'd0, 3'b010, 7'd0, 32'hFFFFFFFC, 1'b1, 32'hFFC12083);
    drain("branch_jal");
  endtask

  task automatic test_shift_bounds();
    do_start();
    send(3'd4, 5'd5, 5'd6, 5'd0, 3'b001, 7'h00, 32'd3,        1'b1, 32'h00331293);
    send(3'd4, 5'd5, 5'd6, 5'd0, 3'b101, 7'h20, 32'd4,        1'b1, 32'h40435293);
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0,  32'd2047,     1'b1, 32'h7FF00093);
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0,  32'hFFFFF800, 1'b1, 32'h80000093);
    drain("shift_bounds");
  endtask

  task automatic test_illegal();
    do_start();
    send(3'd7, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0,        1'b0, 32'h0);
    send(3'd6, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0,        1'b0, 32'h0);
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd7,        1'b0, 32'h0);
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048,     1'b0, 32'h0);
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'b001, 7'd0, 32'd32,       1'b0, 32'h0);
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'b101, 7'd0, 32'hFFFFFFFF, 1'b0, 32'h0);
    send(3'd5, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd17,       1'b0, 32'h0);
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd4096,     1'b0, 32'h0);
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5,        1'b1, 32'h00500093);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_hold got=%b want=1", err);
    end
    drain("illegal");
  endtask

  task automatic test_fill();
    logic [31:0] w;
    do_start();
    send(3'd7, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0, 1'b0, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      w = {12'(k), 5'd0, 3'd0, 5'(k), 7'h13};
      send(3'd4, 5'(k), 5'd0, 5'd0, 3'b000, 7'd0, 32'(k), 1'b1, w);
      checks++;
      if (full !== (k == 4)) begin
        failures++;
        $display("FAIL full_step k=%0d got=%b want=%b", k, full, (k == 4));
      end
    end
    checks++;
    if (wr_en !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_edge got we=%b rdy=%b want we=1 rdy=0", wr_en, in_ready);
    end
    cls = 3'd4; rd = 5'd9; rs1 = 5'd0; funct3 = 3'b000; imm = 32'd9;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd4 || full !== 1'b1 || err !== 1'b1) begin
      failures++;
      $display("FAIL full_ignore got cnt=%0d full=%b err=%b want 4 1 1", count, full, err);
    end
    drain("fill");
    do_start();
  endtask

  task automatic test_start_collision();
    do_start();
    cls = 3'd4; rd = 5'd1; rs1 = 5'd0; funct3 = 3'b000; funct7 = 7'd0; imm = 32'd5;
    in_valid = 1'b1;
    sb.push_back({2'd0, 32'h00500093});
    @(posedge clk); #1;
    imm = 32'd6;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    exp_addr = '0; exp_count = '0;
    checks++;
    if (wr_en !== 1'b0 || count !== 3'd0) begin
      failures++;
      $display("FAIL start_wins got we=%b cnt=%0d want we=0 cnt=0", wr_en, count);
    end
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd7, 1'b1, 32'h00700093);
    drain("start_collision");
  endtask

  task automatic test_reset_mid();
    do_start();
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 1'b1, 32'h00500093);
    send(3'd7, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0, 1'b0, 32'h0);
    cls = 3'd4; rd = 5'd2; imm = 32'd3;
    in_valid = 1'b1;
    sb.push_back({2'd1, 32'h00300113});
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_reset_vals("reset_mid");
    rst_n = 1'b1;
    drain("reset_mid");
  endtask

  initial begin
    exp_addr  = '0;
    exp_count = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_branch_jal();
    test_shift_bounds();
    test_illegal();
    test_fill();
    test_start_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
